div_issue_ctrl: RTL and testbench

Requester-side controller for the M-extension serial divider. It sits in the EX stage between the pipeline and `serdiv`, and decodes DIV/DIVU/REM/REMU. It resolves RISC-V special cases and last-result reuse without the divider. For all other operations it launches `serdiv` with the start/busy/end_valid/flush handshake, stalls the pipeline, and delivers one write-back beat.

---
 rtl/m_ext_pkg.sv | 30 +++
 rtl/div_special_chk.sv | 32 +++
 rtl/div_issue_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_div_issue_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_ext_pkg.sv
// Shared types and constants for the M-extension divide issue path.
package m_ext_pkg;

   localparam int          XLEN_DEFAULT = 32;
   localparam logic [31:0] INT_MIN      = 32'h8000_0000;
   localparam logic [31:0] ALL_ONES     = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_START = 2'b01,
      S_WAIT  = 2'b10,
      S_RESP  = 2'b11
   } div_state_e;

   function automatic logic op_is_signed(input div_op_e op);
      return ~op[0];
   endfunction

   function automatic logic op_is_rem(input div_op_e op);
      return op[1];
   endfunction

endpackage

// File: rtl/div_special_chk.sv
// Resolves divide-by-zero and signed overflow without the serial divider.
module div_special_chk
   import m_ext_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  div_op_e          op,
   input  logic [XLEN-1:0]  rs1,
   input  logic [XLEN-1:0]  rs2,
   output logic             is_special,
   output logic [XLEN-1:0]  special_result
);

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic div_zero;
   logic ovf;

   always_comb begin
      div_zero       = (rs2 == '0);
      ovf            = op_is_signed(op) && (rs1 == MIN_NEG) && (rs2 == '1);
      is_special     = div_zero | ovf;
      special_result = '0;
      // Divide-by-zero takes precedence; overflow needs rs2 = -1 so they never overlap.
      if (div_zero) begin
         special_result = op_is_rem(op) ? rs1 : '1;
      end else if (ovf) begin
         special_result = op_is_rem(op) ? '0 : rs1;
      end
   end

endmodule

// File: rtl/div_issue_ctrl.sv
// EX-stage requester for serdiv: special-case/reuse bypass, start/flush handshake, one wb beat.
//   state   | meaning
//   S_IDLE  | waiting for a divide in EX
//   S_START | operands latched, issuing start once divider is free
//   S_WAIT  | divider running, waiting for end_valid
//   S_RESP  | one-cycle write-back beat, pipeline released
module div_issue_ctrl
   import m_ext_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_valid,
   input  logic [1:0]       i_op,
   input  logic [XLEN-1:0]  i_rs1,
   input  logic [XLEN-1:0]  i_rs2,
   input  logic [4:0]       i_rd,
   input  logic             i_flush,
   output logic             o_stall,
   output logic             o_wb_valid,
   output logic [4:0]       o_wb_rd,
   output logic [XLEN-1:0]  o_wb_data,
   output logic             o_div_start,
   output logic             o_div_flush,
   output logic             o_div_signed,
   output logic [XLEN-1:0]  o_div_dividend,
   output logic [XLEN-1:0]  o_div_divisor,
   input  logic             i_div_busy,
   input  logic             i_div_end_valid,
   input  logic [XLEN-1:0]  i_div_quotient,
   input  logic [XLEN-1:0]  i_div_remainder
);

   div_state_e       state_q, state_d;
   div_op_e          op_in;
   div_op_e          op_q, op_d;
   logic [4:0]       rd_q, rd_d;
   logic             wb_valid_q, wb_valid_d;
   logic [4:0]       wb_rd_q, wb_rd_d;
   logic [XLEN-1:0]  wb_data_q, wb_data_d;
   logic             start_q, start_d;
   logic             flush_q, flush_d;
   logic             signed_q, signed_d;
   logic [XLEN-1:0]  dividend_q, dividend_d;
   logic [XLEN-1:0]  divisor_q, divisor_d;

   logic             ru_valid_q, ru_valid_d;
   logic [XLEN-1:0]  ru_rs1_q, ru_rs1_d;
   logic [XLEN-1:0]  ru_rs2_q, ru_rs2_d;
   logic             ru_signed_q, ru_signed_d;
   logic [XLEN-1:0]  ru_quot_q, ru_quot_d;
   logic [XLEN-1:0]  ru_rem_q, ru_rem_d;

   logic             is_special;
   logic [XLEN-1:0]  special_result;
   logic             reuse_hit;
   logic             stall;

   assign op_in = div_op_e'(i_op);

   div_special_chk #(.XLEN(XLEN)) u_special (
      .op             (op_in),
      .rs1            (i_rs1),
      .rs2            (i_rs2),
      .is_special     (is_special),
      .special_result (special_result)
   );

   assign reuse_hit = ru_valid_q && (ru_rs1_q == i_rs1) && (ru_rs2_q == i_rs2)
                      && (ru_signed_q == op_is_signed(op_in));

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      rd_d        = rd_q;
      wb_valid_d  = 1'b0;
      wb_rd_d     = wb_rd_q;
      wb_data_d   = wb_data_q;
      start_d     = 1'b0;
      flush_d     = 1'b0;
      signed_d    = signed_q;
      dividend_d  = dividend_q;
      divisor_d   = divisor_q;
      ru_valid_d  = ru_valid_q;
      ru_rs1_d    = ru_rs1_q;
      ru_rs2_d    = ru_rs2_q;
      ru_signed_d = ru_signed_q;
      ru_quot_d   = ru_quot_q;
      ru_rem_d    = ru_rem_q;
      stall       = 1'b0;

      case (state_q)
         S_IDLE: begin
            stall = i_valid & ~i_flush;
            if (i_valid && !i_flush) begin
               if (is_special) begin
                  wb_valid_d = 1'b1;
                  wb_data_d  = special_result;
                  wb_rd_d    = i_rd;
                  state_d    = S_RESP;
               end else if (reuse_hit) begin
                  wb_valid_d = 1'b1;
                  wb_data_d  = op_is_rem(op_in) ? ru_rem_q : ru_quot_q;
                  wb_rd_d    = i_rd;
                  state_d    = S_RESP;
               end else begin
                  dividend_d = i_rs1;
                  divisor_d  = i_rs2;
                  signed_d   = op_is_signed(op_in);
                  op_d       = op_in;
                  rd_d       = i_rd;
                  start_d    = ~i_div_busy;
                  state_d    = S_START;
               end
            end
         end
         S_START: begin
            stall = 1'b1;
            if (i_flush) begin
               flush_d = 1'b1;
               state_d = S_IDLE;
            end else if (start_q) begin
               state_d = S_WAIT;
            end else begin
               // start is registered, so it goes out the cycle after busy is seen low
               start_d = ~i_div_busy;
            end
         end
         S_WAIT: begin
            stall = 1'b1;
            if (i_flush) begin
               flush_d = 1'b1;
               state_d = S_IDLE;
            end else if (i_div_end_valid) begin
               wb_valid_d  = 1'b1;
               wb_data_d   = op_is_rem(op_q) ? i_div_remainder : i_div_quotient;
               wb_rd_d     = rd_q;
               ru_valid_d  = 1'b1;
               ru_rs1_d    = dividend_q;
               ru_rs2_d    = divisor_q;
               ru_signed_d = signed_q;
               ru_quot_d   = i_div_quotient;
               ru_rem_d    = i_div_remainder;
               state_d     = S_RESP;
            end
         end
         S_RESP: begin
            stall   = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         op_q        <= OP_DIV;
         rd_q        <= '0;
         wb_valid_q  <= 1'b0;
         wb_rd_q     <= '0;
         wb_data_q   <= '0;
         start_q     <= 1'b0;
         flush_q     <= 1'b0;
         signed_q    <= 1'b0;
         dividend_q  <= '0;
         divisor_q   <= '0;
         ru_valid_q  <= 1'b0;
         ru_rs1_q    <= '0;
         ru_rs2_q    <= '0;
         ru_signed_q <= 1'b0;
         ru_quot_q   <= '0;
         ru_rem_q    <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         rd_q        <= rd_d;
         wb_valid_q  <= wb_valid_d;
         wb_rd_q     <= wb_rd_d;
         wb_data_q   <= wb_data_d;
         start_q     <= start_d;
         flush_q     <= flush_d;
         signed_q    <= signed_d;
         dividend_q  <= dividend_d;
         divisor_q   <= divisor_d;
         ru_valid_q  <= ru_valid_d;
         ru_rs1_q    <= ru_rs1_d;
         ru_rs2_q    <= ru_rs2_d;
         ru_signed_q <= ru_signed_d;
         ru_quot_q   <= ru_quot_d;
         ru_rem_q    <= ru_rem_d;
      end
   end

   assign o_stall        = stall;
   // wb_valid_q is only ever set while in S_RESP, where a kill must drop the beat
   assign o_wb_valid     = wb_valid_q & ~i_flush;
   assign o_wb_rd        = wb_rd_q;
   assign o_wb_data      = wb_data_q;
   assign o_div_start    = start_q;
   assign o_div_flush    = flush_q;
   assign o_div_signed   = signed_q;
   assign o_div_dividend = dividend_q;
   assign o_div_divisor  = divisor_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl; the bench plays the role of serdiv by hand.
module tb_div_issue_ctrl;

   localparam int XLEN = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic             i_valid;
   logic [1:0]       i_op;
   logic [XLEN-1:0]  i_rs1, i_rs2;
   logic [4:0]       i_rd;
   logic             i_flush;
   logic             o_stall, o_wb_valid;
   logic [4:0]       o_wb_rd;
   logic [XLEN-1:0]  o_wb_data;
   logic             o_div_start, o_div_flush, o_div_signed;
   logic [XLEN-1:0]  o_div_dividend, o_div_divisor;
   logic             i_div_busy, i_div_end_valid;
   logic [XLEN-1:0]  i_div_quotient, i_div_remainder;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   div_issue_ctrl #(.XLEN(XLEN)) dut (
      .clk             (clk),
      .reset           (reset),
      .i_valid         (i_valid),
      .i_op            (i_op),
      .i_rs1           (i_rs1),
      .i_rs2           (i_rs2),
      .i_rd            (i_rd),
      .i_flush         (i_flush),
      .o_stall         (o_stall),
      .o_wb_valid      (o_wb_valid),
      .o_wb_rd         (o_wb_rd),
      .o_wb_data       (o_wb_data),
      .o_div_start     (o_div_start),
      .o_div_flush     (o_div_flush),
      .o_div_signed    (o_div_signed),
      .o_div_dividend  (o_div_dividend),
      .o_div_divisor   (o_div_divisor),
      .i_div_busy      (i_div_busy),
      .i_div_end_valid (i_div_end_valid),
      .i_div_quotient  (i_div_quotient),
      .i_div_remainder (i_div_remainder)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      i_valid = 1'b1;
      i_op    = op;
      i_rs1   = a;
      i_rs2   = b;
      i_rd    = rd;
   endtask

   task automatic test_reset();
      #3;
      if ({o_stall, o_wb_valid, o_wb_rd, o_wb_data, o_div_start, o_div_flush, o_div_signed,
           o_div_dividend, o_div_divisor} !== '0) begin
         bad++; $display("FAIL reset_outputs got nonzero wb_data=%h dividend=%h", o_wb_data, o_div_dividend);
      end
      total++;
      step();
      reset = 1'b0;
   endtask

   task automatic test_divu_basic();
      issue(2'b01, 32'd100, 32'd7, 5'd3);
      #1;
      if (o_stall !== 1'b1 || o_div_start !== 1'b0) begin
         bad++; $display("FAIL divu_accept got stall=%0b start=%0b exp stall=1 start=0", o_stall, o_div_start);
      end
      total++;
      step();
      #1;
      if (o_div_start !== 1'b1 || o_div_dividend !== 32'd100 || o_div_divisor !== 32'd7 || o_div_signed !== 1'b0) begin
         bad++; $display("FAIL divu_start got start=%0b a=%0d b=%0d s=%0b exp 1 100 7 0",
                         o_div_start, o_div_dividend, o_div_divisor, o_div_signed);
      end
      total++;
      step();
      i_div_busy = 1'b1;
      #1;
      if (o_div_start !== 1'b0 || o_stall !== 1'b1) begin
         bad++; $display("FAIL divu_wait got start=%0b stall=%0b exp 0 1", o_div_start, o_stall);
      end
      total++;
      step();
      i_div_end_valid = 1'b1; i_div_quotient = 32'd14; i_div_remainder = 32'd2; i_div_busy = 1'b0;
      #1;
      if (o_wb_valid !== 1'b0 || o_stall !== 1'b1) begin
         bad++; $display("FAIL divu_endcycle got wb=%0b stall=%0b exp 0 1", o_wb_valid, o_stall);
      end
      total++;
      step();
      i_div_end_valid = 1'b0;
      #1;
      if (o_wb_valid !== 1'b1 || o_wb_data !== 32'd14 || o_wb_rd !== 5'd3 || o_stall !== 1'b0) begin
         bad++; $display("FAIL divu_resp got wb=%0b data=%0d rd=%0d stall=%0b exp 1 14 3 0",
                         o_wb_valid, o_wb_data, o_wb_rd, o_stall);
      end
      total++;
      step();
      i_valid = 1'b0;
      #1;
      if (o_wb_valid !== 1'b0) begin
         bad++; $display("FAIL divu_single_beat got wb=%0b exp 0", o_wb_valid);
      end
      total++;
   endtask

   task automatic test_special();
      issue(2'b00, 32'd5, 32'd0, 5'd4);
      #1;
      if (o_stall !== 1'b1) begin
         bad++; $display("FAIL div0_stall got %0b exp 1", o_stall);
      end
      total++;
      step();
      #1;
      if (o_wb_valid !== 1'b1 || o_wb_data !== 32'hFFFF_FFFF || o_wb_rd !== 5'd4 || o_div_start !== 1'b0) begin
         bad++; $display("FAIL div0_resp got wb=%0b data=%h rd=%0d start=%0b exp 1 ffffffff 4 0",
                         o_wb_valid, o_wb_data, o_wb_rd, o_div_start);
      end
      total++;
      step();
      issue(2'b11, 32'd5, 32'd0, 5'd6);
      step();
      #1;
      if (o_wb_valid !== 1'b1 || o_wb_data !== 32'd5 || o_div_start !== 1'b0) begin
         bad++; $display("FAIL remu0_resp got wb=%0b data=%h start=%0b exp 1 5 0", o_wb_valid, o_wb_data, o_div_start);
      end
      total++;
      step();
      issue(2'b00, 32'd1, 32'd0, 5'd7);
      step();
      i_flush = 1'b1;
      #1;
      if (o_wb_valid !== 1'b0) begin
         bad++; $display("FAIL flush_resp got wb=%0b exp 0", o_wb_valid);
      end
      total++;
      step();
      issue(2'b00, 32'd9, 32'd0, 5'd8);
      i_flush = 1'b1;
      #1;
      if (o_stall !== 1'b0) begin
         bad++; $display("FAIL flush_idle_stall got %0b exp 0", o_stall);
      end
      total++;
      step();
      i_valid = 1'b0; i_flush = 1'b0;
      #1;
      if (o_wb_valid !== 1'b0 || o_div_start !== 1'b0) begin
         bad++; $display("FAIL flush_idle_ignored got wb=%0b start=%0b exp 0 0", o_wb_valid, o_div_start);
      end
      total++;
   endtask

   task automatic test_overflow();
      issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
      step();
      #1;
      if (o_wb_valid !== 1'b1 || o_wb_data !== 32'h8000_0000 || o_div_start !== 1'b0) begin
         bad++; $display("FAIL ovf_div got wb=%0b data=%h start=%0b exp 1 80000000 0", o_wb_valid, o_wb_data, o_div_start);
      end
      total++;
      step();
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
      step();
      #1;
      if (o_wb_valid !== 1'b1 || o_wb_data !== 32'h0 || o_div_start !== 1'b0) begin
         bad++; $display("FAIL ovf_rem got wb=%0b data=%h start=%0b exp 1 0 0", o_wb_valid, o_wb_data, o_div_start);
      end
      total++;
      step();
      i_valid = 1'b0;
   endtask

   task automatic test_reuse_and_flush();
      issue(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd12);
      step();
      #1;
      if (o_div_start !== 1'b1 || o_div_signed !== 1'b1) begin
         bad++; $display("FAIL sdiv_start got start=%0b signed=%0b exp 1 1", o_div_start, o_div_signed);
      end
      total++;
      step();
      i_div_busy = 1'b1;
      step();
      i_div_end_valid = 1'b1; i_div_quotient = 32'hFFFF_FFFD; i_div_remainder = 32'hFFFF_FFFF; i_div_busy = 1'b0;
      step();
      i_div_end_valid = 1'b0;
      #1;
      if (o_wb_valid !== 1'b1 || o_wb_data !== 32'hFFFF_FFFD || o_wb_rd !== 5'd12) begin
         bad++; $display("FAIL sdiv_resp got wb=%0b data=%h rd=%0d exp 1 fffffffd 12", o_wb_valid, o_wb_data, o_wb_rd);
      end
      total++;
      step();
      issue(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd13);
      step();
      #1;
      if (o_wb_valid !== 1'b1 || o_wb_data !== 32'hFFFF_FFFF || o_wb_rd !== 5'd13 || o_div_start !== 1'b0) begin
         bad++; $display("FAIL reuse_rem got wb=%0b data=%h rd=%0d start=%0b exp 1 ffffffff 13 0",
                         o_wb_valid, o_wb_data, o_wb_rd, o_div_start);
      end
      total++;
      step();
      issue(2'b01, 32'hFFFF_FFF9, 32'd2, 5'd14);
      step();
      #1;
      if (o_div_start !== 1'b1 || o_div_signed !== 1'b0 || o_wb_valid !== 1'b0) begin
         bad++; $display("FAIL reuse_miss_divu got start=%0b signed=%0b wb=%0b exp 1 0 0",
                         o_div_start, o_div_signed, o_wb_valid);
      end
      total++;
      step();
      i_div_busy = 1'b1;
      step();
      i_flush = 1'b1; i_valid = 1'b0;
      #1;
      if (o_stall !== 1'b1 || o_div_flush !== 1'b0) begin
         bad++; $display("FAIL flush_wait_stall got stall=%0b flush=%0b exp 1 0", o_stall, o_div_flush);
      end
      total++;
      step();
      i_flush = 1'b0;
      i_div_end_valid = 1'b1; i_div_quotient = 32'd123; i_div_remainder = 32'd321;
      #1;
      if (o_div_flush !== 1'b1 || o_div_start !== 1'b0 || o_wb_valid !== 1'b0) begin
         bad++; $display("FAIL flush_pulse got flush=%0b start=%0b wb=%0b exp 1 0 0", o_div_flush, o_div_start, o_wb_valid);
      end
      total++;
      step();
      i_div_end_valid = 1'b0;
      #1;
      if (o_div_flush !== 1'b0 || o_wb_valid !== 1'b0) begin
         bad++; $display("FAIL stale_end_ignored got flush=%0b wb=%0b exp 0 0", o_div_flush, o_wb_valid);
      end
      total++;
      issue(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd15);
      step();
      #1;
      if (o_wb_valid !== 1'b1 || o_wb_data !== 32'hFFFF_FFFF || o_div_start !== 1'b0) begin
         bad++; $display("FAIL reuse_after_flush got wb=%0b data=%h start=%0b exp 1 ffffffff 0",
                         o_wb_valid, o_wb_data, o_div_start);
      end
      total++;
      step();
      issue(2'b00, 32'd20, 32'd3, 5'd9);
      step();
      #1;
      if (o_div_start !== 1'b0 || o_stall !== 1'b1) begin
         bad++; $display("FAIL busy_hold1 got start=%0b stall=%0b exp 0 1", o_div_start, o_stall);
      end
      total++;
      step();
      #1;
      if (o_div_start !== 1'b0) begin
         bad++; $display("FAIL busy_hold2 got start=%0b exp 0", o_div_start);
      end
      total++;
      step();
      i_div_busy = 1'b0;
      #1;
      if (o_div_start !== 1'b0) begin
         bad++; $display("FAIL busy_release got start=%0b exp 0", o_div_start);
      end
      total++;
      step();
      #1;
      if (o_div_start !== 1'b1 || o_div_flush !== 1'b0 || o_div_dividend !== 32'd20) begin
         bad++; $display("FAIL busy_start got start=%0b flush=%0b a=%0d exp 1 0 20", o_div_start, o_div_flush, o_div_dividend);
      end
      total++;
      step();
      i_div_busy = 1'b1;
      step();
      i_div_end_valid = 1'b1; i_div_quotient = 32'd6; i_div_remainder = 32'd2; i_div_busy = 1'b0;
      step();
      i_div_end_valid = 1'b0;
      #1;
      if (o_wb_valid !== 1'b1 || o_wb_data !== 32'd6 || o_wb_rd !== 5'd9) begin
         bad++; $display("FAIL busy_resp got wb=%0b data=%0d rd=%0d exp 1 6 9", o_wb_valid, o_wb_data, o_wb_rd);
      end
      total++;
      step();
      i_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      issue(2'b01, 32'd9, 32'd2, 5'd1);
      step();
      step();
      i_div_busy = 1'b1;
      step();
      i_div_end_valid = 1'b1; i_div_quotient = 32'd4; i_div_remainder = 32'd1; i_div_busy = 1'b0;
      step();
      i_div_end_valid = 1'b0;
      #1;
      if (o_wb_valid !== 1'b1 || o_wb_data !== 32'd4) begin
         bad++; $display("FAIL pre_reset_divu got wb=%0b data=%0d exp 1 4", o_wb_valid, o_wb_data);
      end
      total++;
      step();
      issue(2'b00, 32'd11, 32'd4, 5'd2);
      step();
      step();
      i_div_busy = 1'b1;
      i_valid = 1'b0;
      #1;
      reset = 1'b1;
      #1;
      if ({o_stall, o_wb_valid, o_wb_rd, o_wb_data, o_div_start, o_div_flush, o_div_signed,
           o_div_dividend, o_div_divisor} !== '0) begin
         bad++; $display("FAIL reset_mid_outputs got stall=%0b dividend=%h divisor=%h exp all 0",
                         o_stall, o_div_dividend, o_div_divisor);
      end
      total++;
      step();
      #1;
      if (o_div_flush !== 1'b0 || o_stall !== 1'b0) begin
         bad++; $display("FAIL reset_mid_noflush got flush=%0b stall=%0b exp 0 0", o_div_flush, o_stall);
      end
      total++;
      reset = 1'b0; i_div_busy = 1'b0;
      step();
      issue(2'b01, 32'd9, 32'd2, 5'd1);
      step();
      #1;
      if (o_div_start !== 1'b1 || o_wb_valid !== 1'b0) begin
         bad++; $display("FAIL reuse_cleared got start=%0b wb=%0b exp 1 0", o_div_start, o_wb_valid);
      end
      total++;
      step();
      step();
      i_div_end_valid = 1'b1; i_div_quotient = 32'd4; i_div_remainder = 32'd1;
      step();
      i_div_end_valid = 1'b0;
      #1;
      if (o_wb_valid !== 1'b1 || o_wb_data !== 32'd4 || o_wb_rd !== 5'd1) begin
         bad++; $display("FAIL post_reset_resp got wb=%0b data=%0d rd=%0d exp 1 4 1", o_wb_valid, o_wb_data, o_wb_rd);
      end
      total++;
      step();
      i_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      i_valid = 1'b0; i_op = 2'b00; i_rs1 = '0; i_rs2 = '0; i_rd = '0; i_flush = 1'b0;
      i_div_busy = 1'b0; i_div_end_valid = 1'b0; i_div_quotient = '0; i_div_remainder = '0;
      test_reset();
      test_divu_basic();
      test_special();
      test_overflow();
      test_reuse_and_flush();
      test_reset_mid();
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
